// File: rtl/dtcl_afpm_pipe.sv
// 3-stage valid/ready binary32 multiplier: exact 24x24 or DTCL-approximate significand product.
// Latency 3 cycles at 1 op/cycle; when the output holds, stages fill and in_ready drops.
module dtcl_afpm_pipe #(
  parameter int E     = 10,
  parameter int A     = 6,
  parameter int K     = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic             in_exact,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_p,
  output logic [TAG_W-1:0] out_tag
);
  localparam int P  = 2 * (E + A);
  localparam int SI = (E + A < 24) ? 23 - E - A : 0;

  if (A % K != 0) begin : g_bad_chunk
    $error("dtcl_afpm_pipe: A must be a multiple of K");
  end
  if (E < 1 || A < 1 || E + A > 24) begin : g_bad_split
    $error("dtcl_afpm_pipe: need E >= 1, A >= 1 and E + A <= 24");
  end

  // Keep only the leading one of every K-bit chunk.
  function automatic logic [A-1:0] quant(input logic [A-1:0] r);
    logic [A-1:0] q;
    logic         found;
    q = '0;
    for (int c = 0; c < A / K; c++) begin
      found = 1'b0;
      for (int b = K - 1; b >= 0; b--) begin
        if (!found && r[c*K+b]) begin
          q[c*K+b] = 1'b1;
          found    = 1'b1;
        end
      end
    end
    return q;
  endfunction

  // Handshake
  logic s1_vld_q, s2_vld_q, out_vld_q;
  logic ld3, s2_rdy, s1_rdy;

  assign ld3      = !out_vld_q || out_ready;
  assign s2_rdy   = !s2_vld_q || ld3;
  assign s1_rdy   = !s1_vld_q || s2_rdy;
  assign in_ready = s1_rdy;

  // S1: classify, split regions, quantise
  logic         sa, sb, za, zb, ia, ib, na, nb;
  logic [7:0]   ea, eb;
  logic [22:0]  fa, fb;
  logic [23:0]  full_a, full_b;
  logic [A-1:0] ra, rb;

  assign {sa, ea, fa} = in_a;
  assign {sb, eb, fb} = in_b;
  assign za = (ea == 8'd0);
  assign zb = (eb == 8'd0);
  assign ia = (ea == 8'hFF) && (fa == 23'd0);
  assign ib = (eb == 8'hFF) && (fb == 23'd0);
  assign na = (ea == 8'hFF) && (fa != 23'd0);
  assign nb = (eb == 8'hFF) && (fb != 23'd0);
  assign full_a = {~za, fa};
  assign full_b = {~zb, fb};

  always_comb begin
    ra = full_a[23-E -: A];
    rb = full_b[23-E -: A];
    if (E + A < 24) begin
      ra[0] = ra[0] | full_a[SI];
      rb[0] = rb[0] | full_b[SI];
    end
  end

  logic [9:0] s1_esum_d;
  logic       s1_nan_d, s1_zero_d, s1_inf_d;

  assign s1_esum_d = {2'b00, ea} + {2'b00, eb} - 10'd127;
  assign s1_nan_d  = na || nb || (za && ib) || (zb && ia);
  assign s1_zero_d = za || zb;
  assign s1_inf_d  = ia || ib;

  logic [TAG_W-1:0] s1_tag_q;
  logic             s1_exact_q, s1_sign_q, s1_nan_q, s1_zero_q, s1_inf_q;
  logic [9:0]       s1_esum_q;
  logic [23:0]      s1_fa_q, s1_fb_q;
  logic [A-1:0]     s1_aq_q, s1_bq_q;

  // S2: partial products, DTCL result left-aligned into 48 bits
  logic [E-1:0] xe, ye;
  logic [P-1:0] dt_d;
  logic [47:0]  s2_prod_d;

  assign xe = s1_fa_q[23 -: E];
  assign ye = s1_fb_q[23 -: E];

  always_comb begin
    dt_d = ((P'(xe) * P'(ye)) << (2 * A))
         + ((P'(xe) * P'(s1_bq_q) + P'(ye) * P'(s1_aq_q)) << A)
         + P'(s1_aq_q) * P'(s1_bq_q);
    if (s1_exact_q) s2_prod_d = 48'(s1_fa_q) * 48'(s1_fb_q);
    else            s2_prod_d = 48'(dt_d) << (48 - P);
  end

  logic [TAG_W-1:0] s2_tag_q;
  logic             s2_sign_q, s2_nan_q, s2_zero_q, s2_inf_q;
  logic [9:0]       s2_esum_q;
  logic [47:23]     s2_prod_q;
  logic             unused_prod_lsbs;

  assign unused_prod_lsbs = ^s2_prod_d[22:0];

  // S3: normalise (truncate), exponent, special cases
  logic        cin;
  logic [22:0] frac_d;
  logic [9:0]  e_d;
  logic [31:0] p_d;

  assign cin    = s2_prod_q[47];
  assign frac_d = cin ? s2_prod_q[46:24] : s2_prod_q[45:23];
  assign e_d    = s2_esum_q + {9'd0, cin};

  always_comb begin
    p_d = {s2_sign_q, e_d[7:0], frac_d};
    if (s2_nan_q)                          p_d = 32'h7FFF_FFFF;
    else if (s2_zero_q)                    p_d = {s2_sign_q, 31'd0};
    else if (s2_inf_q)                     p_d = {s2_sign_q, 8'hFF, 23'd0};
    else if (e_d[9] || e_d == 10'd0)       p_d = {s2_sign_q, 31'd0};
    else if (e_d >= 10'd255)               p_d = {s2_sign_q, 8'hFF, 23'd0};
  end

  logic [31:0]      out_p_q;
  logic [TAG_W-1:0] out_tag_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      out_vld_q <= 1'b0;
      out_p_q   <= 32'd0;
      out_tag_q <= '0;
    end else begin
      if (s1_rdy) s1_vld_q  <= in_valid;
      if (s2_rdy) s2_vld_q  <= s1_vld_q;
      if (ld3)    out_vld_q <= s2_vld_q;
      if (ld3 && s2_vld_q) begin
        out_p_q   <= p_d;
        out_tag_q <= s2_tag_q;
      end
    end
  end

  // Payload registers need no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (in_valid && s1_rdy) begin
      s1_tag_q   <= in_tag;
      s1_exact_q <= in_exact;
      s1_sign_q  <= sa ^ sb;
      s1_nan_q   <= s1_nan_d;
      s1_zero_q  <= s1_zero_d;
      s1_inf_q   <= s1_inf_d;
      s1_esum_q  <= s1_esum_d;
      s1_fa_q    <= full_a;
      s1_fb_q    <= full_b;
      s1_aq_q    <= quant(ra);
      s1_bq_q    <= quant(rb);
    end
    if (s1_vld_q && s2_rdy) begin
      s2_tag_q  <= s1_tag_q;
      s2_sign_q <= s1_sign_q;
      s2_nan_q  <= s1_nan_q;
      s2_zero_q <= s1_zero_q;
      s2_inf_q  <= s1_inf_q;
      s2_esum_q <= s1_esum_q;
      s2_prod_q <= s2_prod_d[47:23];
    end
  end

  assign out_valid = out_vld_q;
  assign out_p     = out_p_q;
  assign out_tag   = out_tag_q;

endmodule
